// File: rtl/onehot_stream_if.sv
// Handshake bundle for the streaming index-to-one-hot decoder: index beats in,
// decoded one-hot beats out.
interface onehot_stream_if #(
  parameter int OUT_W = 4
);
  localparam int IDX_W = $clog2(OUT_W);

  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] in_idx;
  logic             in_en;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_onehot;
  logic             out_err;

  modport master (
    output in_valid, in_idx, in_en, out_ready,
    input  in_ready, out_valid, out_onehot, out_err
  );

  modport slave (
    input  in_valid, in_idx, in_en, out_ready,
    output in_ready, out_valid, out_onehot, out_err
  );
endinterface

// File: rtl/onehot_decoder_stream.sv
// Registered binary-index to one-hot decoder behind a 2-entry FIFO. Decoding is
// done at accept time so only the decoded word and its error flag are stored.
module onehot_decoder_stream #(
  parameter int OUT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  onehot_stream_if.slave    s,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              busy
);
  localparam int IDX_W = $clog2(OUT_W);
  localparam logic [IDX_W:0] OUT_W_C = (IDX_W + 1)'(OUT_W);

  typedef struct packed {
    logic [OUT_W-1:0] onehot;
    logic             err;
  } beat_t;

  beat_t            mem_q [2];
  beat_t            dec;
  beat_t            head;
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q, count_d;
  logic             in_ready_q;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             out_valid;
  logic             accept, xfer;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    dec = '0;
    if (s.in_en) begin
      if ({1'b0, s.in_idx} < OUT_W_C) dec.onehot[s.in_idx] = 1'b1;
      else                            dec.err              = 1'b1;
    end
  end

  assign out_valid = (count_q != 2'd0);
  assign accept    = s.in_valid & in_ready_q;
  assign xfer      = out_valid & s.out_ready;

  always_comb begin
    count_d   = count_q;
    err_cnt_d = err_cnt_q;
    case ({accept, xfer})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    if (accept && dec.err && !(&err_cnt_q)) err_cnt_d = err_cnt_q + 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      in_ready_q <= 1'b1;
      err_cnt_q  <= '0;
    end else begin
      count_q    <= count_d;
      in_ready_q <= (count_d != 2'd2);
      err_cnt_q  <= err_cnt_d;
      if (accept) wr_ptr_q <= ~wr_ptr_q;
      if (xfer)   rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // NOTE: the storage array has no reset; an empty FIFO masks the head to zero instead.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= dec;
  end

  assign head         = out_valid ? mem_q[rd_ptr_q] : '0;
  assign s.in_ready   = in_ready_q;
  assign s.out_valid  = out_valid;
  assign s.out_onehot = head.onehot;
  assign s.out_err    = head.err;
  assign err_cnt      = err_cnt_q;
  assign busy         = out_valid;

`ifndef SYNTHESIS
  a_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(s.out_onehot));
  a_err_zero: assert property (@(posedge clk) disable iff (rst) s.out_err |-> (s.out_onehot == '0));
  a_full_blocks: assert property (@(posedge clk) disable iff (rst) (count_q == 2'd2) |-> !accept);
  a_count_range: assert property (@(posedge clk) disable iff (rst) count_q <= 2'd2);
`endif
endmodule

// File: tb/tb_onehot_decoder_stream.sv
// Directed bench for onehot_decoder_stream: a 4-wide instance and a 6-wide instance
// with a 2-bit error counter, checked against an expected-beat queue per instance.
module tb_onehot_decoder_stream;
  logic clk;
  logic rst;

  onehot_stream_if #(.OUT_W(4)) a_if ();
  onehot_stream_if #(.OUT_W(6)) b_if ();

  logic [7:0] a_cnt;
  logic       a_busy;
  logic [1:0] b_cnt;
  logic       b_busy;

  onehot_decoder_stream #(.OUT_W(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .s(a_if.slave), .err_cnt(a_cnt), .busy(a_busy)
  );
  onehot_decoder_stream #(.OUT_W(6), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .s(b_if.slave), .err_cnt(b_cnt), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] onehot;
    logic       err;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic exp_t model(input int width, input int idx, input bit en);
    exp_t e;
    e = '0;
    if (en) begin
      if (idx < width) e.onehot[idx] = 1'b1;
      else             e.err         = 1'b1;
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: at the falling edge record accepts and score transfers, then
  // return #1 after the rising edge so stimulus changes away from the edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (a_if.in_valid && a_if.in_ready)
      q_a.push_back(model(4, int'(a_if.in_idx), a_if.in_en));
    if (b_if.in_valid && b_if.in_ready)
      q_b.push_back(model(6, int'(b_if.in_idx), b_if.in_en));
    if (a_if.out_valid && a_if.out_ready) begin
      if (q_a.size() == 0) check("a_unexpected_beat", 32'd1, 32'd0);
      else begin
        e = q_a.pop_front();
        check("a_onehot", 32'(a_if.out_onehot), 32'(e.onehot));
        check("a_err", 32'(a_if.out_err), 32'(e.err));
      end
    end
    if (b_if.out_valid && b_if.out_ready) begin
      if (q_b.size() == 0) check("b_unexpected_beat", 32'd1, 32'd0);
      else begin
        e = q_b.pop_front();
        check("b_onehot", 32'(b_if.out_onehot), 32'(e.onehot));
        check("b_err", 32'(b_if.out_err), 32'(e.err));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && (q_a.size() != 0 || q_b.size() != 0); k++) tick();
    check("drain_a_empty", 32'(q_a.size()), 32'd0);
    check("drain_b_empty", 32'(q_b.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    a_if.in_valid = 1'b0; a_if.in_idx = '0; a_if.in_en = 1'b0; a_if.out_ready = 1'b0;
    b_if.in_valid = 1'b0; b_if.in_idx = '0; b_if.in_en = 1'b0; b_if.out_ready = 1'b0;
    @(posedge clk);
    #1;
    check("rst_in_ready", 32'(a_if.in_ready), 32'd1);
    check("rst_out_valid", 32'(a_if.out_valid), 32'd0);
    check("rst_out_onehot", 32'(a_if.out_onehot), 32'd0);
    check("rst_out_err", 32'(a_if.out_err), 32'd0);
    check("rst_err_cnt", 32'(a_cnt), 32'd0);
    check("rst_busy", 32'(a_busy), 32'd0);
    rst = 1'b0;

    // Full-rate decode of 0..3 with downstream always ready.
    a_if.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_if.in_valid = 1'b1; a_if.in_idx = 2'(i); a_if.in_en = 1'b1;
      tick();
      check("t1_in_ready", 32'(a_if.in_ready), 32'd1);
      if (i == 0) begin
        check("t1_latency_valid", 32'(a_if.out_valid), 32'd1);
        check("t1_latency_onehot", 32'(a_if.out_onehot), 32'b0001);
      end
    end
    a_if.in_valid = 1'b0;
    drain();
    check("t1_err_cnt", 32'(a_cnt), 32'd0);

    // Stall: two beats fill the FIFO, a third is held off until a slot frees.
    a_if.out_ready = 1'b0;
    a_if.in_valid = 1'b1; a_if.in_idx = 2'd3; a_if.in_en = 1'b1;
    tick();
    a_if.in_idx = 2'd1;
    tick();
    check("t2_full_in_ready", 32'(a_if.in_ready), 32'd0);
    check("t2_full_busy", 32'(a_busy), 32'd1);
    check("t2_stall_onehot", 32'(a_if.out_onehot), 32'b1000);
    a_if.in_idx = 2'd2;
    tick();
    tick();
    check("t2_held_in_ready", 32'(a_if.in_ready), 32'd0);
    check("t2_held_queue", 32'(q_a.size()), 32'd2);
    check("t2_held_onehot", 32'(a_if.out_onehot), 32'b1000);
    a_if.out_ready = 1'b1;
    tick();
    check("t2_in_ready_back", 32'(a_if.in_ready), 32'd1);
    tick();
    a_if.in_valid = 1'b0;
    drain();

    // Out-of-range indices on the 6-wide instance.
    b_if.out_ready = 1'b1;
    for (int i = 5; i < 8; i++) begin
      b_if.in_valid = 1'b1; b_if.in_idx = 3'(i); b_if.in_en = 1'b1;
      tick();
    end
    b_if.in_valid = 1'b0;
    drain();
    check("t3_err_cnt", 32'(b_cnt), 32'd2);

    // Disabled decode: zero word, no error, even for an out-of-range index.
    a_if.in_valid = 1'b1; a_if.in_idx = 2'd2; a_if.in_en = 1'b0;
    b_if.in_valid = 1'b1; b_if.in_idx = 3'd7; b_if.in_en = 1'b0;
    tick();
    a_if.in_valid = 1'b0;
    b_if.in_valid = 1'b0;
    drain();
    check("t4_a_err_cnt", 32'(a_cnt), 32'd0);
    check("t4_b_err_cnt", 32'(b_cnt), 32'd2);

    // Saturation of the 2-bit error counter.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q_a.delete();
    q_b.delete();
    check("t5_cnt_after_rst", 32'(b_cnt), 32'd0);
    for (int i = 0; i < 5; i++) begin
      b_if.in_valid = 1'b1; b_if.in_idx = 3'd7; b_if.in_en = 1'b1;
      tick();
      check("t5_err_cnt", 32'(b_cnt), 32'((i + 1 < 3) ? i + 1 : 3));
    end
    b_if.in_valid = 1'b0;
    drain();

    // Reset while full discards both buffered beats at once.
    a_if.out_ready = 1'b0;
    a_if.in_valid = 1'b1; a_if.in_en = 1'b1;
    a_if.in_idx = 2'd0;
    tick();
    a_if.in_idx = 2'd2;
    tick();
    a_if.in_valid = 1'b0;
    check("t6_full_busy", 32'(a_busy), 32'd1);
    check("t6_full_in_ready", 32'(a_if.in_ready), 32'd0);
    rst = 1'b1;
    #1;
    check("t6_rst_out_valid", 32'(a_if.out_valid), 32'd0);
    check("t6_rst_busy", 32'(a_busy), 32'd0);
    check("t6_rst_in_ready", 32'(a_if.in_ready), 32'd1);
    check("t6_rst_b_err_cnt", 32'(b_cnt), 32'd0);
    q_a.delete();
    q_b.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    a_if.out_ready = 1'b1;
    a_if.in_valid = 1'b1; a_if.in_idx = 2'd1; a_if.in_en = 1'b1;
    tick();
    a_if.in_valid = 1'b0;
    repeat (3) tick();
    check("t6_queue_empty", 32'(q_a.size()), 32'd0);
    check("t6_no_stale_valid", 32'(a_if.out_valid), 32'd0);
    check("t6_idle_busy", 32'(a_busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
